// File: rtl/rr_arb_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux_4_1
// Purpose  : Registered 4-source round-robin arbiter feeding a 4:1 data mux.
//            Each cycle one valid source is granted and its data captured
//            into a one-entry output register. The winning index is exported
//            as a 2-bit select for the downstream datapath.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            d0..d3    - source data, W bits each
//            vld[3:0]  - per-source valid
//            rdy[3:0]  - per-source ready (combinational, at most one high)
//            out_data  - registered data of the held entry
//            out_sel   - registered index of the source that produced it
//            out_vld   - output entry valid
//            out_rdy   - downstream ready
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_mux_4_1 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [3:0]   vld,
  output logic [3:0]   rdy,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  output logic         out_vld,
  input  logic         out_rdy
);

  localparam int         C_NSRC      = 4;
  // Pointer reset value: the search starts one past it, so source 0 leads.
  localparam logic [1:0] C_LAST_INIT = 2'd3;

  logic [1:0]   r_last;
  logic [W-1:0] r_data;
  logic [1:0]   r_sel;
  logic         r_vld;

  logic         w_can_load;
  logic         w_gnt_any;
  logic         w_load;
  logic [1:0]   w_gnt_idx;
  logic [1:0]   w_cand;
  logic         w_found;
  logic [W-1:0] w_gnt_data;

  // The register may accept a new entry when it is empty or draining now.
  // out_rdy only reaches rdy and the register enables, never the outputs.
  assign w_can_load = ~r_vld | out_rdy;
  assign w_gnt_any  = |vld;
  assign w_load     = w_can_load & w_gnt_any;

  // Rotating priority search: last+1, last+2, last+3, last (mod 4).
  // The 2-bit add wraps naturally, and k=4 lands back on last itself.
  always_comb begin
    w_gnt_idx = r_last;
    w_found   = 1'b0;
    w_cand    = r_last;
    for (int k = 1; k <= C_NSRC; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_found && vld[w_cand]) begin
        w_gnt_idx = w_cand;
        w_found   = 1'b1;
      end
    end
  end

  // 4:1 data mux steered by the grant index.
  always_comb begin
    w_gnt_data = d0;
    case (w_gnt_idx)
      2'd0: w_gnt_data = d0;
      2'd1: w_gnt_data = d1;
      2'd2: w_gnt_data = d2;
      2'd3: w_gnt_data = d3;
      default: w_gnt_data = d0;
    endcase
  end

  // One-hot ready: only the winner sees rdy, and only when loading is possible.
  genvar gi;
  generate
    for (gi = 0; gi < C_NSRC; gi++) begin : g_rdy
      assign rdy[gi] = w_load & (w_gnt_idx == 2'(gi));
    end
  endgenerate

  // Output register and round-robin pointer. The pointer only moves on an
  // accepted transfer, so stalls and idle cycles keep the same priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_sel  <= 2'd0;
      r_last <= C_LAST_INIT;
    end else if (w_load) begin
      r_vld  <= 1'b1;
      r_data <= w_gnt_data;
      r_sel  <= w_gnt_idx;
      r_last <= w_gnt_idx;
    end else if (w_can_load) begin
      // Draining with nothing to refill: empty the entry, keep data/sel.
      r_vld  <= 1'b0;
    end
  end

  assign out_data = r_data;
  assign out_sel  = r_sel;
  assign out_vld  = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux_4_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_mux_4_1
// Purpose  : Self-checking bench for rr_arb_mux_4_1. Directed scenarios
//            followed by randomized stress compared against a behavioural
//            round-robin model and an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux_4_1;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   vld;
  logic [3:0]   rdy;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_vld;
  logic         out_rdy;

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .vld      (vld),
    .rdy      (rdy),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    int src;
    int data;
  } ent_t;

  ent_t         sb[$];
  logic         m_vld;
  logic [W-1:0] m_data;
  logic [1:0]   m_sel;
  int           m_last;
  int           m_acc;
  int           wait_cnt[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // First valid index walking forward from one past the last winner.
  function automatic int pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] src_data(input int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_sel  = 2'd0;
    m_last = 3;
    m_acc  = -1;
    sb.delete();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  // One clock cycle. Inputs must already be applied (after posedge+1).
  task automatic tick();
    int   g;
    bit   can_load;
    ent_t e;
    @(negedge clk);
    can_load = !m_vld || out_rdy;
    g = pick(m_last, vld);
    check("rdy", {28'd0, rdy}, (can_load && g >= 0) ? (32'd1 << g) : 32'd0);
    // Fairness measured on the DUT's own grants.
    for (int i = 0; i < 4; i++) begin
      if (!vld[i] || rdy[i]) begin
        wait_cnt[i] = 0;
      end else if (rdy != 4'd0) begin
        wait_cnt[i]++;
        check("fair_wait_gt3", {31'd0, wait_cnt[i] > 3}, 32'd0);
      end
    end
    // Drain: held entry must be the oldest accepted pair.
    if (m_vld && out_rdy) begin
      check("sb_depth", sb.size(), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_sel", {30'd0, out_sel}, e.src);
        check("sb_data", {28'd0, out_data}, e.data);
      end
    end
    m_acc = -1;
    if (can_load && g >= 0) begin
      m_vld  = 1'b1;
      m_data = src_data(g);
      m_sel  = 2'(g);
      m_last = g;
      m_acc  = g;
      sb.push_back('{g, int'(src_data(g))});
    end else if (can_load) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_vld", {31'd0, out_vld}, {31'd0, m_vld});
    check("out_data", {28'd0, out_data}, {28'd0, m_data});
    check("out_sel", {30'd0, out_sel}, {30'd0, m_sel});
  endtask

  int seq_sel[5]  = '{0, 1, 2, 3, 0};
  int seq_data[5] = '{1, 2, 3, 4, 1};
  int seq_rdy[5]  = '{1, 2, 4, 8, 1};

  initial begin
    rst = 1'b1;
    vld = 4'd0;
    out_rdy = 1'b0;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", {31'd0, out_vld}, 32'd0);
    check("rst_data", {28'd0, out_data}, 32'd0);
    check("rst_sel", {30'd0, out_sel}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset priority: all sources valid, order 0,1,2,3,0
    vld = 4'b1111;
    out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rp_rdy", {28'd0, rdy}, seq_rdy[k]);
      tick();
      check("rp_sel", {30'd0, out_sel}, seq_sel[k]);
      check("rp_data", {28'd0, out_data}, seq_data[k]);
    end
    tick();
    check("bp_setup_sel", {30'd0, out_sel}, 32'd1);
    check("bp_setup_data", {28'd0, out_data}, 32'd2);

    // Backpressure: hold for 3 cycles, then resume with source 2
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_rdy", {28'd0, rdy}, 32'd0);
      tick();
      check("bp_hold_vld", {31'd0, out_vld}, 32'd1);
      check("bp_hold_data", {28'd0, out_data}, 32'd2);
      check("bp_hold_sel", {30'd0, out_sel}, 32'd1);
    end
    out_rdy = 1'b1;
    #1;
    check("bp_resume_rdy", {28'd0, rdy}, 32'b0100);
    tick();
    check("bp_resume_sel", {30'd0, out_sel}, 32'd2);

    // Sparse / wrap
    vld = 4'b1000;
    tick();
    check("sw_last3_sel", {30'd0, out_sel}, 32'd3);
    vld = 4'b0100;
    d2 = 4'd9;
    #1;
    check("sw_rdy", {28'd0, rdy}, 32'b0100);
    tick();
    check("sw_data", {28'd0, out_data}, 32'd9);
    check("sw_sel", {30'd0, out_sel}, 32'd2);
    vld = 4'b0101;
    tick();
    check("sw_wrap_sel", {30'd0, out_sel}, 32'd0);
    tick();
    check("sw_next_sel", {30'd0, out_sel}, 32'd2);

    // Drain to empty, pointer must not move
    vld = 4'b0000;
    tick();
    check("dr_vld", {31'd0, out_vld}, 32'd0);
    check("dr_data", {28'd0, out_data}, 32'd9);
    check("dr_sel", {30'd0, out_sel}, 32'd2);
    vld = 4'b1111;
    #1;
    check("dr_ptr_rdy", {28'd0, rdy}, 32'b1000);
    tick();
    check("dr_ptr_sel", {30'd0, out_sel}, 32'd3);

    // Asynchronous reset between edges while holding an entry
    #2;
    rst = 1'b1;
    vld = 4'b0000;
    #1;
    check("ar_vld", {31'd0, out_vld}, 32'd0);
    check("ar_data", {28'd0, out_data}, 32'd0);
    check("ar_sel", {30'd0, out_sel}, 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ar_idle_vld", {31'd0, out_vld}, 32'd0);
    vld = 4'b1010;
    tick();
    check("ar_first_sel", {30'd0, out_sel}, 32'd1);
    check("ar_first_data", {28'd0, out_data}, 32'd2);

    // Random stress: sources tend to stay valid until granted
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i] && m_acc != i) vld[i] = ($urandom_range(0, 7) != 0);
        else                      vld[i] = ($urandom_range(0, 1) != 0);
      end
      if (m_acc != 0 || $urandom_range(0, 1) != 0) d0 = W'($urandom_range(0, 15));
      if (m_acc != 1 || $urandom_range(0, 1) != 0) d1 = W'($urandom_range(0, 15));
      if (m_acc != 2 || $urandom_range(0, 1) != 0) d2 = W'($urandom_range(0, 15));
      if (m_acc != 3 || $urandom_range(0, 1) != 0) d3 = W'($urandom_range(0, 15));
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Final drain
    vld = 4'b0000;
    out_rdy = 1'b1;
    tick();
    check("final_vld", {31'd0, out_vld}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
